// File: rtl/hazard_if.sv
// hazard_if: pipeline-control bundle between the hazard controller (slave) and the core datapath (master); HAZARD_PERF_CNT_EN adds perf counters
interface hazard_if #(parameter int CNT_W = 16);
  logic [31:0] inst_d_i;
  logic [4:0] rsW_ex_i;
  logic RegWEn_ex_i;
  logic MemRd_ex_i;
  logic br_taken_ex_i;
  logic mem_busy_i;
  logic pc_en_o;
  logic if_id_en_o;
  logic if_id_rst_o;
  logic id_ex_en_o;
  logic id_ex_rst_o;
  logic ex_mem_en_o;
  logic mem_wb_en_o;
  logic mem_wb_rst_o;
  logic stall_o;
  logic flush_o;
  logic err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] freeze_cnt_o;
  modport slave (
    input inst_d_i, rsW_ex_i, RegWEn_ex_i, MemRd_ex_i, br_taken_ex_i, mem_busy_i,
    output pc_en_o, if_id_en_o, if_id_rst_o, id_ex_en_o, id_ex_rst_o, ex_mem_en_o,
           mem_wb_en_o, mem_wb_rst_o, stall_o, flush_o, err_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );
  modport master (
    output inst_d_i, rsW_ex_i, RegWEn_ex_i, MemRd_ex_i, br_taken_ex_i, mem_busy_i,
    input pc_en_o, if_id_en_o, if_id_rst_o, id_ex_en_o, id_ex_rst_o, ex_mem_en_o,
          mem_wb_en_o, mem_wb_rst_o, stall_o, flush_o, err_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );
`else
  modport slave (
    input inst_d_i, rsW_ex_i, RegWEn_ex_i, MemRd_ex_i, br_taken_ex_i, mem_busy_i,
    output pc_en_o, if_id_en_o, if_id_rst_o, id_ex_en_o, id_ex_rst_o, ex_mem_en_o,
           mem_wb_en_o, mem_wb_rst_o, stall_o, flush_o, err_o
  );
  modport master (
    output inst_d_i, rsW_ex_i, RegWEn_ex_i, MemRd_ex_i, br_taken_ex_i, mem_busy_i,
    input pc_en_o, if_id_en_o, if_id_rst_o, id_ex_en_o, id_ex_rst_o, ex_mem_en_o,
          mem_wb_en_o, mem_wb_rst_o, stall_o, flush_o, err_o
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipe stall/flush/freeze sequencing with freeze watchdog; HAZARD_PERF_CNT_EN adds stall/flush/freeze counters
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  hazard_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, FREEZE = 2'd1, ERR = 2'd2;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [6:0] op;
  logic rs1_used, rs2_used, hz, busy, br, unused_inst;
  assign op = bus.inst_d_i[6:0];
  assign busy = bus.mem_busy_i;
  assign br = bus.br_taken_ex_i;
  assign unused_inst = ^{bus.inst_d_i[31:25], bus.inst_d_i[14:7]};
  // decode source usage and the load-use hazard against the load in EX
  always_comb begin
    rs1_used = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    rs2_used = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    hz = bus.MemRd_ex_i && bus.RegWEn_ex_i && bus.rsW_ex_i != 5'd0 &&
         ((rs1_used && bus.inst_d_i[19:15] == bus.rsW_ex_i) ||
          (rs2_used && bus.inst_d_i[24:20] == bus.rsW_ex_i));
  end
  // freeze length counts every busy cycle including the entry cycle, so ERR lands after TIMEOUT frozen cycles
  always_comb begin
    cnt_d = !busy ? '0 : (cnt_q == TMO ? cnt_q : cnt_q + 1'b1);
    state_d = !busy ? RUN : ((state_q == ERR || cnt_d == TMO) ? ERR : FREEZE);
    err_d = err_q || state_d == ERR;
  end
  // state, counter and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // pipe enables/clears: reset > freeze > flush > load-use > normal
  always_comb begin
    bus.pc_en_o = rst_i || (!busy && (br || !hz));
    bus.if_id_en_o = rst_i || (!busy && (br || !hz));
    bus.if_id_rst_o = rst_i || (!busy && br);
    bus.id_ex_en_o = rst_i || !busy;
    bus.id_ex_rst_o = rst_i || (!busy && (br || hz));
    bus.ex_mem_en_o = rst_i || !busy;
    bus.mem_wb_en_o = 1'b1;
    bus.mem_wb_rst_o = rst_i || busy;
    bus.stall_o = !rst_i && !busy && !br && hz;
    bus.flush_o = !rst_i && !busy && br;
    bus.err_o = err_q;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  // saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(bus.stall_o && !(&stall_cnt_q));
      flush_cnt_q <= flush_cnt_q + CNT_W'(bus.flush_o && !(&flush_cnt_q));
      freeze_cnt_q <= freeze_cnt_q + CNT_W'(busy && !(&freeze_cnt_q));
    end
  end
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
  assign bus.freeze_cnt_o = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int TMO = 4;
  localparam int CW = 16;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int frz_n = 0;
  bit err_m = 1'b0;
  int sc = 0, fc = 0, zc = 0;
  logic [10:0] obs;
  logic [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                           7'b1101111, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};
  always #5 clk = ~clk;
  hazard_if #(.CNT_W(CW)) bus();
  hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  assign obs = {bus.pc_en_o, bus.if_id_en_o, bus.if_id_rst_o, bus.id_ex_en_o, bus.id_ex_rst_o,
                bus.ex_mem_en_o, bus.mem_wb_en_o, bus.mem_wb_rst_o, bus.stall_o, bus.flush_o, bus.err_o};
  // expected {pc_en,if_id_en,if_id_rst,id_ex_en,id_ex_rst,ex_mem_en,mem_wb_en,mem_wb_rst,stall,flush,err}
  function automatic logic [10:0] model();
    logic [6:0] op;
    bit u1, u2, h;
    op = bus.inst_d_i[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    h = bus.MemRd_ex_i && bus.RegWEn_ex_i && bus.rsW_ex_i != 0 &&
        ((u1 && bus.inst_d_i[19:15] == bus.rsW_ex_i) || (u2 && bus.inst_d_i[24:20] == bus.rsW_ex_i));
    if (rst) return {10'b11111111_00, err_m};
    if (bus.mem_busy_i) return {10'b00000011_00, err_m};
    if (bus.br_taken_ex_i) return {10'b11111110_01, err_m};
    if (h) return {10'b00011110_10, err_m};
    return {10'b11010110_00, err_m};
  endfunction
  task automatic tick();
    logic [10:0] e;
    e = model();
    if (rst) begin
      frz_n = 0; err_m = 0; sc = 0; fc = 0; zc = 0;
    end else begin
      if (bus.mem_busy_i) begin
        frz_n = frz_n < TMO ? frz_n + 1 : TMO;
        if (frz_n == TMO) err_m = 1;
      end else frz_n = 0;
      if (e[2] && sc < MAXC) sc++;
      if (e[1] && fc < MAXC) fc++;
      if (bus.mem_busy_i && zc < MAXC) zc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_in(logic [31:0] inst, logic [4:0] rsw, logic regw, logic memrd, logic br, logic busy);
    bus.inst_d_i = inst; bus.rsW_ex_i = rsw; bus.RegWEn_ex_i = regw;
    bus.MemRd_ex_i = memrd; bus.br_taken_ex_i = br; bus.mem_busy_i = busy;
    #1;
  endtask
  task automatic do_reset();
    rst = 1; set_in(32'h0, 5'd0, 0, 0, 0, 0); tick(); rst = 0; #1;
  endtask
  task automatic test_reset();
    logic [10:0] e;
    @(negedge clk);
    rst = 1; set_in($urandom, 5'($urandom), 1, 1, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      set_in($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      e = model(); n_chk++;
      if (obs !== e) $display("FAIL reset[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
      n_chk++;
      if (obs !== 11'b11111111_000) $display("FAIL reset_const[%0d] got=%b exp=%b", i, obs, 11'b11111111_000); else n_pass++;
      tick();
    end
    rst = 0; set_in(32'h00000013, 5'd0, 0, 0, 0, 0);
    e = model(); n_chk++;
    if (obs !== e) $display("FAIL reset_idle got=%b exp=%b", obs, e); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o} !== 48'd0)
      $display("FAIL reset_cnt got=%h exp=0", {bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o}); else n_pass++;
`endif
    tick();
  endtask
  task automatic test_load_use();
    logic [10:0] e;
    do_reset();
    set_in(32'h00128333, 5'd5, 1, 1, 0, 0);
    e = model(); n_chk++;
    if (obs !== e || e[2] !== 1'b1) $display("FAIL load_use got=%b exp=%b", obs, e); else n_pass++;
    tick();
    set_in(32'h00128333, 5'd0, 0, 0, 0, 0);
    e = model(); n_chk++;
    if (obs !== e || e[2] !== 1'b0) $display("FAIL load_use_next got=%b exp=%b", obs, e); else n_pass++;
    tick();
  endtask
  task automatic test_non_hazard();
    logic [31:0] insts [3] = '{32'h00028333, 32'h000282b7, 32'h00508313};
    logic [4:0] rsws [3] = '{5'd0, 5'd5, 5'd5};
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      set_in(insts[i], rsws[i], 1, 1, 0, 0);
      e = model(); n_chk++;
      if (obs !== e || obs[2] !== 1'b0) $display("FAIL non_hazard[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
      tick();
    end
  endtask
  task automatic test_branch();
    logic [10:0] e;
    set_in(32'h00128333, 5'd5, 1, 1, 1, 0);
    e = model(); n_chk++;
    if (obs !== e || e[2:1] !== 2'b01) $display("FAIL branch got=%b exp=%b", obs, e); else n_pass++;
    tick();
    set_in(32'h00000013, 5'd0, 0, 0, 0, 0);
    e = model(); n_chk++;
    if (obs !== e) $display("FAIL branch_next got=%b exp=%b", obs, e); else n_pass++;
    tick();
  endtask
  task automatic test_freeze();
    logic [10:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(32'h00128333, 5'd5, 1, 1, 1, 1);
      e = model(); n_chk++;
      if (obs !== e) $display("FAIL freeze[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
      tick();
    end
    set_in(32'h00128333, 5'd5, 1, 1, 1, 0);
    e = model(); n_chk++;
    if (obs !== e || e[1] !== 1'b1) $display("FAIL freeze_release got=%b exp=%b", obs, e); else n_pass++;
    tick();
  endtask
  task automatic test_timeout();
    logic [10:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(32'h00000013, 5'd0, 0, 0, 0, 1);
      e = model(); n_chk++;
      if (obs !== e || e[0] !== (i >= TMO)) $display("FAIL timeout[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(32'h00000013, 5'd0, 0, 0, 0, 0);
      e = model(); n_chk++;
      if (obs !== e || e[0] !== 1'b1) $display("FAIL timeout_sticky[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
      tick();
    end
    do_reset();
    e = model(); n_chk++;
    if (obs !== e || e[0] !== 1'b0) $display("FAIL timeout_clear got=%b exp=%b", obs, e); else n_pass++;
    tick();
  endtask
  task automatic test_reset_mid_freeze();
    logic [10:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(32'h00000013, 5'd0, 0, 0, 0, 1); tick();
    end
    rst = 1; set_in(32'h00000013, 5'd0, 0, 0, 0, 1);
    e = model(); n_chk++;
    if (obs !== e) $display("FAIL mid_freeze_rst got=%b exp=%b", obs, e); else n_pass++;
    tick();
    rst = 0; set_in(32'h00000013, 5'd0, 0, 0, 0, 0);
    e = model(); n_chk++;
    if (obs !== e || e !== 11'b11010110_000) $display("FAIL mid_freeze_run got=%b exp=%b", obs, e); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o} !== 48'd0)
      $display("FAIL mid_freeze_cnt got=%h exp=0", {bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o}); else n_pass++;
`endif
    tick();
  endtask
  task automatic test_random();
    logic [10:0] e;
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) < 2);
      set_in(r, 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20);
      e = model(); n_chk++;
      if (obs !== e) $display("FAIL random[%0d] got=%b exp=%b", i, obs, e); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_chk++;
      if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o} !== {CW'(sc), CW'(fc), CW'(zc)})
        $display("FAIL random_cnt[%0d] got=%h exp=%h", i, {bus.stall_cnt_o, bus.flush_cnt_o, bus.freeze_cnt_o},
                 {CW'(sc), CW'(fc), CW'(zc)}); else n_pass++;
`endif
      tick();
    end
    rst = 0;
  endtask
  initial begin
    bus.inst_d_i = '0; bus.rsW_ex_i = '0; bus.RegWEn_ex_i = 0;
    bus.MemRd_ex_i = 0; bus.br_taken_ex_i = 0; bus.mem_busy_i = 0;
    test_reset();
    test_load_use();
    test_non_hazard();
    test_branch();
    test_freeze();
    test_timeout();
    test_reset_mid_freeze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Drives the enable/reset (stall/flush) inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards from the instruction in ID, flushes on taken branches/jumps resolved in EX, and freezes the pipe while data memory is busy.
- Includes a freeze-timeout watchdog.

Parameters:
- TIMEOUT, 64, freeze cycles tolerated before err_o sets (range 1..65535).
- CNT_W, 16, width of the freeze-length counter and the perf counters.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- inst_d_i  in  32  instruction currently in ID
- rsW_ex_i  in  5  destination register of the instruction in EX
- RegWEn_ex_i  in  1  EX instruction writes the register file
- MemRd_ex_i  in  1  EX instruction is a load
- br_taken_ex_i  in  1  taken branch/JAL/JALR resolved in EX
- mem_busy_i  in  1  data memory not ready; MEM must hold
- pc_en_o  out  1  PC register enable
- if_id_en_o, if_id_rst_o  out  1 each  IF/ID enable / synchronous clear
- id_ex_en_o, id_ex_rst_o  out  1 each  ID/EX enable / clear (the ID stage enable_i/reset_i)
- ex_mem_en_o  out  1  EX/MEM enable
- mem_wb_en_o, mem_wb_rst_o  out  1 each  MEM/WB enable / clear
- stall_o  out  1  load-use bubble inserted this cycle
- flush_o  out  1  branch flush this cycle
- err_o  out  1  sticky freeze-timeout error

Behaviour:
- Reset (rst_i=1, sampled at posedge):
  - State returns to RUN; freeze counter = 0; err_o = 0.
  - While rst_i is high, all *_en_o = 1 and all *_rst_o = 1, clearing every pipe register; stall_o = flush_o = 0.
- FSM states:
  - RUN → FREEZE when mem_busy_i = 1.
  - FREEZE → RUN when mem_busy_i = 0.
  - FREEZE → ERR when the freeze counter reaches TIMEOUT.
  - ERR → RUN when mem_busy_i = 0; err_o stays set until rst_i.
- Freeze counter:
  - Increments each cycle in FREEZE, saturating at TIMEOUT.
  - Clears on the transition to RUN.
- Outputs are combinational from state and current inputs, so they act in the same cycle.
- Source usage decode, from inst_d_i[6:0]:
  - rs1 used unless opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - rs2 used only for R (0110011), S (0100011) and B (1100011).
- Load-use hazard: MemRd_ex_i & RegWEn_ex_i & rsW_ex_i≠0 & ((rs1 used & inst_d_i[19:15]==rsW_ex_i) | (rs2 used & inst_d_i[24:20]==rsW_ex_i)).
- Priority, highest first, evaluated each cycle:
  1. Freeze (mem_busy_i=1, or state FREEZE/ERR with mem_busy_i still 1): pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 and mem_wb_rst=1 (bubble into WB); stall_o = flush_o = 0.
  2. Flush (br_taken_ex_i): pc_en=1; if_id_en=1, if_id_rst=1; id_ex_en=1, id_ex_rst=1; ex_mem_en=1; flush_o=1. Any coincident load-use hazard is discarded because the hazarding instruction is killed.
  3. Load-use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_rst=1, ex_mem_en=1, stall_o=1. Exactly one bubble; next cycle the load is in MEM and the hazard clears.
  4. Normal: all enables 1, all clears 0.
- Freeze release: inputs held during the freeze are re-evaluated in the first cycle with mem_busy_i=0. A pending branch or hazard acts in that cycle.
- Unused register x0 never causes a stall. Branch and hazard on the same cycle: flush only.
- Reset asserted mid-freeze: freeze abandoned, counter and err_o cleared next edge.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o, flush_cnt_o and freeze_cnt_o, each CNT_W wide.
  - They count cycles with stall_o=1, flush_o=1 and freeze active, respectively.
  - All saturate at all-ones and clear on rst_i.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load-use: EX = lw x5 (MemRd=1, RegWEn=1, rsW=5), ID = add x6,x5,x1 (0x00128333) → one cycle of pc_en=0, if_id_en=0, id_ex_rst=1, stall_o=1; next cycle all enables 1, stall_o=0.
- Non-hazards:
  - rsW_ex_i=0 → no stall.
  - ID = lui x5 with rsW_ex_i=5 → no stall (rs1 unused).
  - ID = addi using rs2 field bits = 5 → no stall (rs2 unused).
- Branch: br_taken_ex_i=1 together with a load-use hazard → if_id_rst=1, id_ex_rst=1, pc_en=1, flush_o=1, stall_o=0 for exactly one cycle.
- Freeze: mem_busy_i=1 for 10 cycles while br_taken_ex_i=1 → pc/if_id/id_ex/ex_mem enables 0 and mem_wb_rst=1 for 10 cycles; flush_o=1 in the first cycle after busy drops.
- Timeout: TIMEOUT=4, mem_busy_i=1 for 6 cycles → err_o rises after the 4th frozen cycle, stays 1 after busy drops, clears only after rst_i=1.
- Reset mid-freeze: assert rst_i at freeze cycle 2 → all en=1/rst=1 while reset is high; then RUN with normal enables and err_o=0. With HAZARD_PERF_CNT_EN, all counters read 0.
